// File: rtl/bin_act_packer.sv
`default_nettype none
// ============================================================================
// Module  : bin_act_packer
// Brief   : Thresholds signed activation beats to single bits and transposes
//           PARAM_CH_CNT beats into a double-banked [DIM][CH_CNT] binary frame.
// Revision: 1.0  initial release
// ============================================================================
module bin_act_packer #(
    parameter int PARAM_DIM    = 16,
    parameter int PARAM_CH_CNT = 8,
    parameter int PARAM_BIT    = 8,
    localparam int CH_W = (PARAM_CH_CNT > 1) ? $clog2(PARAM_CH_CNT) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [PARAM_DIM-1:0][PARAM_BIT-1:0]      value_i,
    input  logic [PARAM_DIM-1:0][PARAM_BIT-1:0]      thresh_i,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [PARAM_DIM-1:0][PARAM_CH_CNT-1:0]   bi_result_o,
    output logic [CH_W-1:0]                          ch_idx_o
);

    localparam logic [0:0]      ST_FILLING = 1'b0;
    localparam logic [0:0]      ST_FULL    = 1'b1;
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(PARAM_CH_CNT - 1);

    logic [PARAM_DIM-1:0][PARAM_CH_CNT-1:0] bank_mem [2];
    logic [0:0]                             bank_state [2];
    logic                                   wr_bank;
    logic                                   rd_bank;
    logic [CH_W-1:0]                        ch_cnt;
    logic [1:0]                             full_cnt;

    logic [PARAM_DIM-1:0] bin_bits;
    logic                 accept;
    logic                 wr_en;
    logic                 frame_done;
    logic                 pop;

    // Equality maps to +1; the compare is done at full signed width.
    genvar d;
    generate
        for (d = 0; d < PARAM_DIM; d++) begin : g_bin
            assign bin_bits[d] = ($signed(value_i[d]) >= $signed(thresh_i[d]));
        end
    endgenerate

    assign accept     = in_valid_i && in_ready_o;
    assign wr_en      = accept && (bank_state[wr_bank] == ST_FILLING);
    assign frame_done = wr_en && (ch_cnt == LAST_CH);
    assign pop        = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            ch_cnt   <= '0;
            full_cnt <= 2'd0;
            for (int b = 0; b < 2; b++) begin
                bank_mem[b]   <= '0;
                bank_state[b] <= ST_FILLING;
            end
        end else begin
            if (wr_en) begin
                for (int i = 0; i < PARAM_DIM; i++) begin
                    bank_mem[wr_bank][i][ch_cnt] <= bin_bits[i];
                end
                if (frame_done) begin
                    ch_cnt              <= '0;
                    wr_bank             <= ~wr_bank;
                    bank_state[wr_bank] <= ST_FULL;
                end else begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end
            end

            // With one frame held, the write bank is always the other bank,
            // so a simultaneous complete and pop touch different entries.
            if (pop) begin
                rd_bank             <= ~rd_bank;
                bank_state[rd_bank] <= ST_FILLING;
            end

            case ({frame_done, pop})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    assign in_ready_o  = (full_cnt != 2'd2);
    assign out_valid_o = (full_cnt != 2'd0);
    assign bi_result_o = bank_mem[rd_bank];
    assign ch_idx_o    = ch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bin_act_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bin_act_packer
// Brief   : Directed self-checking bench for bin_act_packer.
// Revision: 1.0  initial release
// ============================================================================
module tb_bin_act_packer;

    localparam int DIM  = 16;
    localparam int CH   = 8;
    localparam int BW   = 8;
    localparam int CH_W = 3;

    typedef logic [DIM-1:0][BW-1:0] vec_t;
    typedef logic [DIM-1:0][CH-1:0] frame_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid_i;
    logic            in_ready_o;
    vec_t            value_i;
    vec_t            thresh_i;
    logic            out_valid_o;
    logic            out_ready_i;
    frame_t          bi_result_o;
    logic [CH_W-1:0] ch_idx_o;

    int n_checks = 0;
    int n_pass   = 0;

    bin_act_packer #(
        .PARAM_DIM    (DIM),
        .PARAM_CH_CNT (CH),
        .PARAM_BIT    (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .value_i     (value_i),
        .thresh_i    (thresh_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .bi_result_o (bi_result_o),
        .ch_idx_o    (ch_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bit of neuron d in beat k for each directed frame pattern.
    function automatic logic pat_bit(input int id, input int d, input int k);
        case (id)
            0:       return 1'((d + k) & 1);
            1:       return (d % 8) == k;
            2:       return (d % 8) != k;
            3:       return 1'(((d >> 1) + k) & 1);
            4:       return 1'((d * k) & 1);
            5:       return d < (k * 2);
            default: return ((d ^ k) & 2) != 0;
        endcase
    endfunction

    function automatic vec_t make_vals(input int id, input int k);
        vec_t v;
        for (int d = 0; d < DIM; d++) v[d] = pat_bit(id, d, k) ? 8'sd10 : -8'sd10;
        return v;
    endfunction

    function automatic frame_t exp_frame(input int id);
        frame_t f;
        for (int d = 0; d < DIM; d++)
            for (int k = 0; k < CH; k++) f[d][k] = pat_bit(id, d, k);
        return f;
    endfunction

    // Leaves in_valid_i high so back-to-back calls stream without gaps.
    task automatic send_beat(input vec_t v, input vec_t t);
        logic took = 1'b0;
        int   waited = 0;
        value_i    = v;
        thresh_i   = t;
        in_valid_i = 1'b1;
        while (!took && waited < 50) begin
            took = in_ready_o;
            tick();
            waited++;
        end
        check("beat_accept", 128'(took), 128'(1'b1));
    endtask

    task automatic send_frame_beats(input int id, input int first, input int last);
        for (int k = first; k <= last; k++) send_beat(make_vals(id, k), '0);
    endtask

    initial begin
        vec_t   v;
        vec_t   t;
        frame_t ef;

        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        value_i     = '0;
        thresh_i    = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_in_ready",  128'(in_ready_o),  128'(1'b1));
        check("rst_out_valid", 128'(out_valid_o), 128'(1'b0));
        check("rst_bi_result", 128'(bi_result_o), 128'(0));
        check("rst_ch_idx",    128'(ch_idx_o),    128'(0));

        // Threshold edges: beat 0 at thresh 0, beat 1 at thresh 5.
        v = '0;
        v[0] = 8'h80; v[1] = 8'hFF; v[2] = 8'h00; v[3] = 8'h01; v[4] = 8'h7F;
        send_beat(v, '0);
        for (int d = 0; d < DIM; d++) begin
            v[d] = (d % 2 == 0) ? 8'sd5 : 8'sd4;
            t[d] = 8'sd5;
        end
        send_beat(v, t);
        for (int k = 2; k < CH; k++) send_beat('0, '0);
        in_valid_i = 1'b0;
        for (int d = 0; d < DIM; d++) begin
            ef[d]    = '1;
            ef[d][0] = (d >= 2);
            ef[d][1] = (d % 2 == 0);
        end
        check("thr_valid", 128'(out_valid_o), 128'(1'b1));
        check("thr_frame", 128'(bi_result_o), 128'(ef));
        out_ready_i = 1'b1;
        tick();
        check("thr_popped", 128'(out_valid_o), 128'(1'b0));

        // Transpose with downstream always ready.
        send_frame_beats(0, 0, 6);
        check("tr_not_yet", 128'(out_valid_o), 128'(1'b0));
        check("tr_ch_idx7", 128'(ch_idx_o),    128'(7));
        send_frame_beats(0, 7, 7);
        in_valid_i = 1'b0;
        check("tr_valid", 128'(out_valid_o), 128'(1'b1));
        check("tr_frame", 128'(bi_result_o), 128'(exp_frame(0)));
        tick();
        check("tr_popped", 128'(out_valid_o), 128'(1'b0));

        // Backpressure: two frames fill both banks, a third beat is held.
        out_ready_i = 1'b0;
        send_frame_beats(1, 0, 7);
        check("bp_valid_f1", 128'(out_valid_o), 128'(1'b1));
        check("bp_ready_f1", 128'(in_ready_o),  128'(1'b1));
        send_frame_beats(2, 0, 7);
        check("bp_ready_full", 128'(in_ready_o), 128'(1'b0));
        value_i = make_vals(3, 0);
        repeat (3) tick();
        check("bp_held_ready", 128'(in_ready_o),  128'(1'b0));
        check("bp_held_chidx", 128'(ch_idx_o),    128'(0));
        check("bp_f1_stable",  128'(bi_result_o), 128'(exp_frame(1)));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("bp_f2_frame",  128'(bi_result_o), 128'(exp_frame(2)));
        check("bp_f2_valid",  128'(out_valid_o), 128'(1'b1));
        check("bp_ready_ret", 128'(in_ready_o),  128'(1'b1));
        check("bp_chidx_pre", 128'(ch_idx_o),    128'(0));
        tick();
        in_valid_i = 1'b0;
        check("bp_held_taken", 128'(ch_idx_o),    128'(1));
        check("bp_f2_stable",  128'(bi_result_o), 128'(exp_frame(2)));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("bp_drained", 128'(out_valid_o), 128'(1'b0));
        send_frame_beats(3, 1, 7);
        in_valid_i = 1'b0;
        check("bp_f3_frame", 128'(bi_result_o), 128'(exp_frame(3)));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Last beat of a new frame completes on the same edge as a pop.
        send_frame_beats(4, 0, 7);
        send_frame_beats(5, 0, 6);
        check("sim_old_frame", 128'(bi_result_o), 128'(exp_frame(4)));
        value_i     = make_vals(5, 7);
        out_ready_i = 1'b1;
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("sim_valid", 128'(out_valid_o), 128'(1'b1));
        check("sim_ready", 128'(in_ready_o),  128'(1'b1));
        check("sim_frame", 128'(bi_result_o), 128'(exp_frame(5)));
        out_ready_i = 1'b1;
        tick();
        check("sim_single", 128'(out_valid_o), 128'(1'b0));

        // Reset mid-frame discards the partial frame.
        send_frame_beats(2, 0, 4);
        in_valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_ch_idx",    128'(ch_idx_o),    128'(0));
        check("mid_out_valid", 128'(out_valid_o), 128'(1'b0));
        check("mid_bi_result", 128'(bi_result_o), 128'(0));
        out_ready_i = 1'b0;
        send_frame_beats(6, 0, 7);
        in_valid_i = 1'b0;
        check("mid_valid", 128'(out_valid_o), 128'(1'b1));
        check("mid_frame", 128'(bi_result_o), 128'(exp_frame(6)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
